// File: rtl/sd_pwr_pkg.sv
// -----------------------------------------------------------------------------
// sd_pwr_pkg
// Shared definitions for the SD power management slice.
//   - 2-bit power_state codes understood by sd_power_controller
//   - manager FSM state encoding (visible on mgr_state_o)
//   - small helpers that map between manager states and power codes
// -----------------------------------------------------------------------------
package sd_pwr_pkg;

    localparam logic [1:0] PWR_ACTIVE_STATE     = 2'b00;
    localparam logic [1:0] PWR_IDLE_STATE       = 2'b01;
    localparam logic [1:0] PWR_SLEEP_STATE      = 2'b10;
    localparam logic [1:0] PWR_POWER_DOWN_STATE = 2'b11;

    localparam int TIMER_W = 16;

    typedef enum logic [2:0] {
        MGR_OFF    = 3'd0,
        MGR_ACTIVE = 3'd1,
        MGR_IDLE   = 3'd2,
        MGR_SLEEP  = 3'd3,
        MGR_WAIT   = 3'd4,
        MGR_FAULT  = 3'd5
    } mgr_state_t;

    // Power code that a stable manager state corresponds to.
    function automatic logic [1:0] mgr_to_pwr(input mgr_state_t s);
        logic [1:0] p;
        case (s)
            MGR_ACTIVE: p = PWR_ACTIVE_STATE;
            MGR_IDLE:   p = PWR_IDLE_STATE;
            MGR_SLEEP:  p = PWR_SLEEP_STATE;
            default:    p = PWR_POWER_DOWN_STATE;
        endcase
        return p;
    endfunction

    // Stable manager state reached once a transition to power code p completes.
    function automatic mgr_state_t pwr_to_mgr(input logic [1:0] p);
        mgr_state_t s;
        case (p)
            PWR_ACTIVE_STATE: s = MGR_ACTIVE;
            PWR_IDLE_STATE:   s = MGR_IDLE;
            PWR_SLEEP_STATE:  s = MGR_SLEEP;
            default:          s = MGR_OFF;
        endcase
        return s;
    endfunction

    // Rails are expected up for ACTIVE/IDLE and down for SLEEP/OFF.
    function automatic logic pgood_expected(input logic [1:0] p);
        return (p == PWR_ACTIVE_STATE) || (p == PWR_IDLE_STATE);
    endfunction

endpackage

// File: rtl/sd_pwr_idle_timer.sv
// -----------------------------------------------------------------------------
// sd_pwr_idle_timer
// Saturating up-counter with synchronous clear and count enable, plus an
// equality compare against a programmable value.
//   clk_i   in  clock
//   rst_ni  in  asynchronous active-low reset
//   clr_i   in  clear counter to 0 (wins over en_i)
//   en_i    in  increment (holds at all-ones)
//   cmp_i   in  compare value
//   eq_o    out current count equals cmp_i
// -----------------------------------------------------------------------------
module sd_pwr_idle_timer
    import sd_pwr_pkg::*;
#(
    parameter int W = TIMER_W
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         clr_i,
    input  logic         en_i,
    input  logic [W-1:0] cmp_i,
    output logic         eq_o
);

    logic [W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i && (cnt_q != {W{1'b1}})) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign eq_o = (cnt_q == cmp_i);

endmodule

// File: rtl/sd_power_manager.sv
// -----------------------------------------------------------------------------
// sd_power_manager
// Policy/sequencing controller in front of sd_power_controller. Accepts host
// power-state requests (valid/ready), generates autonomous IDLE/SLEEP requests
// from an inactivity timer, wakes on activity, confirms every transition
// against power_good with a timeout and escalates faults.
//   PCLK_i, PRESETn_i     clock, asynchronous active-low reset
//   host_req_*            request handshake (state: 00 act,01 idle,10 sleep,11 off)
//   voltage_sel_i         voltage captured when heading to ACTIVE
//   auto_en_i             enables inactivity timers and wake
//   activity_i, wake_i    activity / external wake
//   power_good_i          rail status from sd_power_controller
//   power_fault_i         fault from sd_power_controller
//   fault_clear_i         host acknowledge of FAULT
//   power_state_o         power_state to sd_power_controller
//   voltage_sel_o         voltage_sel to sd_power_controller
//   mgr_state_o           manager state (OFF0 ACT1 IDLE2 SLEEP3 WAIT4 FAULT5)
//   busy_o                transition in progress
//   timeout_err_o         one-cycle pulse on power_good timeout
//   fault_irq_o           one-cycle pulse on FAULT entry
// -----------------------------------------------------------------------------
module sd_power_manager
    import sd_pwr_pkg::*;
#(
    parameter logic [15:0] IDLE_TIMEOUT  = 16'd1000,
    parameter logic [15:0] SLEEP_TIMEOUT = 16'd8000,
    parameter logic [15:0] PGOOD_TIMEOUT = 16'd1024
) (
    input  logic       PCLK_i,
    input  logic       PRESETn_i,
    input  logic       host_req_valid_i,
    input  logic [1:0] host_req_state_i,
    output logic       host_req_ready_o,
    input  logic [3:0] voltage_sel_i,
    input  logic       auto_en_i,
    input  logic       activity_i,
    input  logic       wake_i,
    input  logic       power_good_i,
    input  logic       power_fault_i,
    input  logic       fault_clear_i,
    output logic [1:0] power_state_o,
    output logic [3:0] voltage_sel_o,
    output logic [2:0] mgr_state_o,
    output logic       busy_o,
    output logic       timeout_err_o,
    output logic       fault_irq_o
);

    mgr_state_t state_q, state_d;
    logic [1:0] target_q, target_d;
    logic [1:0] power_state_q, power_state_d;
    logic [3:0] voltage_sel_q, voltage_sel_d;
    logic       timeout_err_q, timeout_err_d;
    logic       fault_irq_q, fault_irq_d;

    logic        in_auto_zone;
    logic        inact_clr, inact_en, inact_hit;
    logic [15:0] inact_cmp;
    logic        wait_clr, wait_en, wait_hit;
    logic        wake_hit, auto_hit, pgood_met, fault_go;
    logic        req_go;
    logic [1:0]  req_tgt;

    // Inactivity counting only happens in ACTIVE/IDLE with auto enabled;
    // everywhere else it is held at 0, which also gives the clear-on-entry.
    assign in_auto_zone = (state_q == MGR_ACTIVE) || (state_q == MGR_IDLE);
    assign inact_clr    = !in_auto_zone || activity_i || !auto_en_i;
    assign inact_en     = 1'b1;
    assign inact_cmp    = (state_q == MGR_ACTIVE) ? IDLE_TIMEOUT : SLEEP_TIMEOUT;

    // WAIT counter reads 0 on the first WAIT cycle.
    assign wait_clr = (state_q != MGR_WAIT);
    assign wait_en  = 1'b1;

    sd_pwr_idle_timer #(.W(16)) u_inact_timer (
        .clk_i  (PCLK_i),
        .rst_ni (PRESETn_i),
        .clr_i  (inact_clr),
        .en_i   (inact_en),
        .cmp_i  (inact_cmp),
        .eq_o   (inact_hit)
    );

    sd_pwr_idle_timer #(.W(16)) u_wait_timer (
        .clk_i  (PCLK_i),
        .rst_ni (PRESETn_i),
        .clr_i  (wait_clr),
        .en_i   (wait_en),
        .cmp_i  (PGOOD_TIMEOUT),
        .eq_o   (wait_hit)
    );

    assign wake_hit  = auto_en_i && (wake_i || activity_i) &&
                       ((state_q == MGR_IDLE) || (state_q == MGR_SLEEP));
    // Activity in the same cycle means the link is not inactive.
    assign auto_hit  = auto_en_i && !activity_i && in_auto_zone && inact_hit;
    assign pgood_met = pgood_expected(target_q) ? power_good_i : !power_good_i;
    assign fault_go  = power_fault_i && (state_q != MGR_OFF) && (state_q != MGR_FAULT);

    // State register
    always_ff @(posedge PCLK_i or negedge PRESETn_i) begin
        if (!PRESETn_i) begin
            state_q       <= MGR_OFF;
            target_q      <= PWR_POWER_DOWN_STATE;
            power_state_q <= PWR_POWER_DOWN_STATE;
            voltage_sel_q <= 4'h0;
            timeout_err_q <= 1'b0;
            fault_irq_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            target_q      <= target_d;
            power_state_q <= power_state_d;
            voltage_sel_q <= voltage_sel_d;
            timeout_err_q <= timeout_err_d;
            fault_irq_q   <= fault_irq_d;
        end
    end

    // Next-state logic: fault > host > wake > inactivity timeout
    always_comb begin
        state_d       = state_q;
        target_d      = target_q;
        power_state_d = power_state_q;
        voltage_sel_d = voltage_sel_q;
        timeout_err_d = 1'b0;
        fault_irq_d   = 1'b0;
        req_go        = 1'b0;
        req_tgt       = target_q;

        // A host request for the current state is accepted but swallowed,
        // and still blocks lower-priority autonomous requests that cycle.
        if (host_req_valid_i) begin
            if (host_req_state_i != mgr_to_pwr(state_q)) begin
                req_go  = 1'b1;
                req_tgt = host_req_state_i;
            end
        end else if (wake_hit) begin
            req_go  = 1'b1;
            req_tgt = PWR_ACTIVE_STATE;
        end else if (auto_hit) begin
            req_go  = 1'b1;
            req_tgt = (state_q == MGR_ACTIVE) ? PWR_IDLE_STATE : PWR_SLEEP_STATE;
        end

        if (fault_go) begin
            state_d       = MGR_FAULT;
            power_state_d = PWR_POWER_DOWN_STATE;
            fault_irq_d   = 1'b1;
        end else begin
            case (state_q)
                MGR_WAIT: begin
                    // Completion is checked before the timeout so it wins a tie.
                    if (pgood_met) begin
                        state_d = pwr_to_mgr(target_q);
                    end else if (wait_hit) begin
                        state_d       = MGR_FAULT;
                        power_state_d = PWR_POWER_DOWN_STATE;
                        timeout_err_d = 1'b1;
                        fault_irq_d   = 1'b1;
                    end
                end
                MGR_FAULT: begin
                    if (fault_clear_i && !power_fault_i) begin
                        state_d = MGR_OFF;
                    end
                end
                MGR_OFF, MGR_ACTIVE, MGR_IDLE, MGR_SLEEP: begin
                    if (req_go) begin
                        state_d       = MGR_WAIT;
                        target_d      = req_tgt;
                        power_state_d = req_tgt;
                        if (req_tgt == PWR_ACTIVE_STATE) begin
                            voltage_sel_d = voltage_sel_i;
                        end
                    end
                end
                default: begin
                    state_d       = MGR_OFF;
                    power_state_d = PWR_POWER_DOWN_STATE;
                end
            endcase
        end
    end

    // Outputs
    always_comb begin
        host_req_ready_o = (state_q == MGR_OFF) || (state_q == MGR_ACTIVE) ||
                           (state_q == MGR_IDLE) || (state_q == MGR_SLEEP);
        busy_o           = (state_q == MGR_WAIT);
        mgr_state_o      = state_q;
        power_state_o    = power_state_q;
        voltage_sel_o    = voltage_sel_q;
        timeout_err_o    = timeout_err_q;
        fault_irq_o      = fault_irq_q;
    end

endmodule

// File: tb/tb_sd_power_manager.sv
module tb_sd_power_manager;

    localparam int IDLE_T  = 16;
    localparam int SLEEP_T = 32;
    localparam int PG_T    = 20;

    logic       clk = 1'b0;
    logic       PRESETn_i;
    logic       host_req_valid_i;
    logic [1:0] host_req_state_i;
    logic       host_req_ready_o;
    logic [3:0] voltage_sel_i;
    logic       auto_en_i, activity_i, wake_i;
    logic       power_good_i, power_fault_i, fault_clear_i;
    logic [1:0] power_state_o;
    logic [3:0] voltage_sel_o;
    logic [2:0] mgr_state_o;
    logic       busy_o, timeout_err_o, fault_irq_o;

    always #5 clk = ~clk;

    sd_power_manager #(
        .IDLE_TIMEOUT  (16'd16),
        .SLEEP_TIMEOUT (16'd32),
        .PGOOD_TIMEOUT (16'd20)
    ) dut (
        .PCLK_i           (clk),
        .PRESETn_i        (PRESETn_i),
        .host_req_valid_i (host_req_valid_i),
        .host_req_state_i (host_req_state_i),
        .host_req_ready_o (host_req_ready_o),
        .voltage_sel_i    (voltage_sel_i),
        .auto_en_i        (auto_en_i),
        .activity_i       (activity_i),
        .wake_i           (wake_i),
        .power_good_i     (power_good_i),
        .power_fault_i    (power_fault_i),
        .fault_clear_i    (fault_clear_i),
        .power_state_o    (power_state_o),
        .voltage_sel_o    (voltage_sel_o),
        .mgr_state_o      (mgr_state_o),
        .busy_o           (busy_o),
        .timeout_err_o    (timeout_err_o),
        .fault_irq_o      (fault_irq_o)
    );

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    // States: 0 OFF, 1 ACTIVE, 2 IDLE, 3 SLEEP, 4 WAIT, 5 FAULT.
    // Power codes: 0 active, 1 idle, 2 sleep, 3 power-down.
    int m_st, m_pw, m_vs, m_tgt, m_quiet, m_waited;
    bit m_tmo, m_irq;

    function automatic int code_of_state(input int s);
        if (s >= 1 && s <= 3) return s - 1;
        return 3;
    endfunction

    function automatic int state_of_code(input int c);
        if (c == 3) return 0;
        return c + 1;
    endfunction

    task automatic model_reset();
        m_st = 0; m_pw = 3; m_vs = 0; m_tgt = 3;
        m_quiet = 0; m_waited = 0; m_tmo = 0; m_irq = 0;
    endtask

    task automatic model_step();
        int ns, npw, nvs, ntgt, req;
        bit ntmo, nirq, stable;
        ns = m_st; npw = m_pw; nvs = m_vs; ntgt = m_tgt;
        ntmo = 0; nirq = 0; req = -1;
        stable = (m_st <= 3);
        if (power_fault_i && m_st != 0 && m_st != 5) begin
            ns = 5; npw = 3; nirq = 1;
        end else if (m_st == 4) begin
            if ((m_tgt <= 1) == power_good_i) ns = state_of_code(m_tgt);
            else if (m_waited == PG_T) begin ns = 5; npw = 3; ntmo = 1; nirq = 1; end
        end else if (m_st == 5) begin
            if (fault_clear_i && !power_fault_i) ns = 0;
        end else if (stable) begin
            if (host_req_valid_i) begin
                if (int'(host_req_state_i) != code_of_state(m_st)) req = int'(host_req_state_i);
            end else if (auto_en_i && (m_st == 2 || m_st == 3) && (wake_i || activity_i)) begin
                req = 0;
            end else if (auto_en_i && !activity_i && m_st == 1 && m_quiet == IDLE_T) begin
                req = 1;
            end else if (auto_en_i && !activity_i && m_st == 2 && m_quiet == SLEEP_T) begin
                req = 2;
            end
            if (req >= 0) begin
                ns = 4; ntgt = req; npw = req;
                if (req == 0) nvs = int'(voltage_sel_i);
            end
        end
        if ((m_st == 1 || m_st == 2) && auto_en_i && !activity_i)
            m_quiet = (m_quiet >= 65535) ? 65535 : m_quiet + 1;
        else
            m_quiet = 0;
        m_waited = (m_st == 4) ? m_waited + 1 : 0;
        m_st = ns; m_pw = npw; m_vs = nvs; m_tgt = ntgt; m_tmo = ntmo; m_irq = nirq;
    endtask

    task automatic compare_model();
        check($sformatf("model_state@%0d", cyc), 32'(mgr_state_o), m_st);
        check($sformatf("model_pwr@%0d", cyc), 32'(power_state_o), m_pw);
        check($sformatf("model_vsel@%0d", cyc), 32'(voltage_sel_o), m_vs);
        check($sformatf("model_ready@%0d", cyc), 32'(host_req_ready_o), 32'(m_st <= 3));
        check($sformatf("model_busy@%0d", cyc), 32'(busy_o), 32'(m_st == 4));
        check($sformatf("model_tmo@%0d", cyc), 32'(timeout_err_o), 32'(m_tmo));
        check($sformatf("model_irq@%0d", cyc), 32'(fault_irq_o), 32'(m_irq));
    endtask

    task automatic step();
        model_step();
        @(posedge clk);
        #1;
        cyc++;
        compare_model();
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic       v;
        logic [1:0] rs;
        logic [3:0] vs;
        logic       ae, act, wk, pg, pf, fc;
        int         n;
        logic [2:0] e_st;
        logic [1:0] e_pw;
        logic [3:0] e_vs;
        logic       e_rdy, e_bsy, e_tmo, e_irq;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(input logic v, input logic [1:0] rs, input logic [3:0] vs,
                                input logic ae, input logic act, input logic wk,
                                input logic pg, input logic pf, input logic fc, input int n,
                                input logic [2:0] st, input logic [1:0] pw, input logic [3:0] evs,
                                input logic rdy, input logic bsy, input logic tmo, input logic irq);
        vec_t r;
        r.v = v; r.rs = rs; r.vs = vs; r.ae = ae; r.act = act; r.wk = wk;
        r.pg = pg; r.pf = pf; r.fc = fc; r.n = n;
        r.e_st = st; r.e_pw = pw; r.e_vs = evs;
        r.e_rdy = rdy; r.e_bsy = bsy; r.e_tmo = tmo; r.e_irq = irq;
        return r;
    endfunction

    task automatic run_rows(input int lo, input int hi);
        for (int r = lo; r <= hi; r++) begin
            host_req_valid_i = tbl[r].v;
            host_req_state_i = tbl[r].rs;
            voltage_sel_i    = tbl[r].vs;
            auto_en_i        = tbl[r].ae;
            activity_i       = tbl[r].act;
            wake_i           = tbl[r].wk;
            power_good_i     = tbl[r].pg;
            power_fault_i    = tbl[r].pf;
            fault_clear_i    = tbl[r].fc;
            for (int k = 0; k < tbl[r].n; k++) step();
            check($sformatf("row%0d_state", r), 32'(mgr_state_o), 32'(tbl[r].e_st));
            check($sformatf("row%0d_pwr", r), 32'(power_state_o), 32'(tbl[r].e_pw));
            check($sformatf("row%0d_vsel", r), 32'(voltage_sel_o), 32'(tbl[r].e_vs));
            check($sformatf("row%0d_ready", r), 32'(host_req_ready_o), 32'(tbl[r].e_rdy));
            check($sformatf("row%0d_busy", r), 32'(busy_o), 32'(tbl[r].e_bsy));
            check($sformatf("row%0d_tmo", r), 32'(timeout_err_o), 32'(tbl[r].e_tmo));
            check($sformatf("row%0d_irq", r), 32'(fault_irq_o), 32'(tbl[r].e_irq));
        end
    endtask

    initial begin
        //            v rs    vs   ae act wk pg pf fc  n   st pw  vs  rdy bsy tmo irq
        // host ACTIVE from OFF, auto IDLE then SLEEP, wake
        tbl.push_back(mk(1, 2'd0, 4'h1, 0, 0, 0, 0, 0, 0,  1, 4, 0, 4'h1, 0, 1, 0, 0)); // 0
        tbl.push_back(mk(0, 2'd0, 4'h1, 0, 0, 0, 0, 0, 0,  4, 4, 0, 4'h1, 0, 1, 0, 0)); // 1
        tbl.push_back(mk(0, 2'd0, 4'h1, 0, 0, 0, 1, 0, 0,  1, 1, 0, 4'h1, 1, 0, 0, 0)); // 2
        tbl.push_back(mk(0, 2'd0, 4'h1, 1, 0, 0, 1, 0, 0, 16, 1, 0, 4'h1, 1, 0, 0, 0)); // 3
        tbl.push_back(mk(0, 2'd0, 4'h1, 1, 0, 0, 1, 0, 0,  1, 4, 1, 4'h1, 0, 1, 0, 0)); // 4
        tbl.push_back(mk(0, 2'd0, 4'h1, 1, 0, 0, 1, 0, 0,  1, 2, 1, 4'h1, 1, 0, 0, 0)); // 5
        tbl.push_back(mk(0, 2'd0, 4'h1, 1, 0, 0, 1, 0, 0, 32, 2, 1, 4'h1, 1, 0, 0, 0)); // 6
        tbl.push_back(mk(0, 2'd0, 4'h1, 1, 0, 0, 1, 0, 0,  1, 4, 2, 4'h1, 0, 1, 0, 0)); // 7
        tbl.push_back(mk(0, 2'd0, 4'h1, 1, 0, 0, 1, 0, 0,  3, 4, 2, 4'h1, 0, 1, 0, 0)); // 8
        tbl.push_back(mk(0, 2'd0, 4'h1, 1, 0, 0, 0, 0, 0,  1, 3, 2, 4'h1, 1, 0, 0, 0)); // 9
        tbl.push_back(mk(0, 2'd0, 4'h6, 1, 0, 1, 0, 0, 0,  1, 4, 0, 4'h6, 0, 1, 0, 0)); // 10
        tbl.push_back(mk(0, 2'd0, 4'h6, 1, 0, 0, 1, 0, 0,  1, 1, 0, 4'h6, 1, 0, 0, 0)); // 11
        // priority and same-state requests
        tbl.push_back(mk(0, 2'd0, 4'h6, 1, 1, 0, 1, 0, 0,  1, 1, 0, 4'h6, 1, 0, 0, 0)); // 12
        tbl.push_back(mk(0, 2'd0, 4'h6, 1, 0, 0, 1, 0, 0, 16, 1, 0, 4'h6, 1, 0, 0, 0)); // 13
        tbl.push_back(mk(1, 2'd1, 4'h9, 1, 0, 1, 1, 0, 0,  1, 4, 1, 4'h6, 0, 1, 0, 0)); // 14
        tbl.push_back(mk(0, 2'd1, 4'h9, 1, 0, 0, 1, 0, 0,  1, 2, 1, 4'h6, 1, 0, 0, 0)); // 15
        tbl.push_back(mk(1, 2'd1, 4'h9, 1, 0, 0, 1, 0, 0,  1, 2, 1, 4'h6, 1, 0, 0, 0)); // 16
        tbl.push_back(mk(1, 2'd2, 4'h9, 1, 0, 1, 1, 0, 0,  1, 4, 2, 4'h6, 0, 1, 0, 0)); // 17
        tbl.push_back(mk(0, 2'd2, 4'h9, 1, 0, 0, 0, 0, 0,  1, 3, 2, 4'h6, 1, 0, 0, 0)); // 18
        // power_good timeout, fault handling, OFF re-entry
        tbl.push_back(mk(1, 2'd0, 4'h3, 0, 0, 0, 0, 0, 0,  1, 4, 0, 4'h3, 0, 1, 0, 0)); // 19
        tbl.push_back(mk(0, 2'd0, 4'h3, 0, 0, 0, 0, 0, 0, 20, 4, 0, 4'h3, 0, 1, 0, 0)); // 20
        tbl.push_back(mk(0, 2'd0, 4'h3, 0, 0, 0, 0, 0, 0,  1, 5, 3, 4'h3, 0, 0, 1, 1)); // 21
        tbl.push_back(mk(0, 2'd0, 4'h3, 0, 0, 0, 0, 0, 0,  1, 5, 3, 4'h3, 0, 0, 0, 0)); // 22
        tbl.push_back(mk(0, 2'd0, 4'h3, 0, 0, 0, 0, 1, 1,  1, 5, 3, 4'h3, 0, 0, 0, 0)); // 23
        tbl.push_back(mk(0, 2'd0, 4'h3, 0, 0, 0, 0, 1, 0,  2, 5, 3, 4'h3, 0, 0, 0, 0)); // 24
        tbl.push_back(mk(0, 2'd0, 4'h3, 0, 0, 0, 0, 0, 1,  1, 0, 3, 4'h3, 1, 0, 0, 0)); // 25
        tbl.push_back(mk(1, 2'd0, 4'h2, 0, 0, 0, 0, 0, 0,  1, 4, 0, 4'h2, 0, 1, 0, 0)); // 26
        tbl.push_back(mk(0, 2'd0, 4'h2, 0, 0, 0, 1, 0, 0,  1, 1, 0, 4'h2, 1, 0, 0, 0)); // 27
        tbl.push_back(mk(0, 2'd0, 4'h2, 0, 0, 0, 1, 1, 0,  1, 5, 3, 4'h2, 0, 0, 0, 1)); // 28
        tbl.push_back(mk(0, 2'd0, 4'h2, 0, 0, 0, 1, 0, 1,  1, 0, 3, 4'h2, 1, 0, 0, 0)); // 29
        tbl.push_back(mk(1, 2'd3, 4'h2, 0, 0, 0, 1, 0, 0,  1, 0, 3, 4'h2, 1, 0, 0, 0)); // 30

        host_req_valid_i = 0; host_req_state_i = 0; voltage_sel_i = 0;
        auto_en_i = 0; activity_i = 0; wake_i = 0;
        power_good_i = 0; power_fault_i = 0; fault_clear_i = 0;
        PRESETn_i = 0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        compare_model();
        check("reset_state", 32'(mgr_state_o), 0);
        check("reset_pwr", 32'(power_state_o), 3);
        check("reset_ready", 32'(host_req_ready_o), 1);
        PRESETn_i = 1;

        run_rows(0, 11);

        // In ACTIVE with activity every 10 cycles the idle timeout never fires.
        for (int i = 0; i < 60; i++) begin
            activity_i = (i % 10 == 0);
            step();
            check($sformatf("keepalive_state%0d", i), 32'(mgr_state_o), 1);
        end
        activity_i = 0;

        run_rows(12, 30);

        // Asynchronous reset in the middle of a WAIT.
        host_req_valid_i = 1; host_req_state_i = 2'd0; voltage_sel_i = 4'h5;
        power_good_i = 0; fault_clear_i = 0; power_fault_i = 0;
        step();
        host_req_valid_i = 0;
        step();
        check("pre_reset_busy", 32'(busy_o), 1);
        #2;
        PRESETn_i = 0;
        #1;
        model_reset();
        compare_model();
        check("async_reset_state", 32'(mgr_state_o), 0);
        check("async_reset_pwr", 32'(power_state_o), 3);
        check("async_reset_vsel", 32'(voltage_sel_o), 0);
        check("async_reset_busy", 32'(busy_o), 0);
        check("async_reset_ready", 32'(host_req_ready_o), 1);
        @(posedge clk);
        #1;
        compare_model();
        check("reset_hold_pulses", 32'({timeout_err_o, fault_irq_o}), 0);
        PRESETn_i = 1;

        // Randomized traffic against the model.
        auto_en_i = 1;
        for (int i = 0; i < 3000; i++) begin
            host_req_valid_i = ($urandom_range(0, 7) == 0);
            host_req_state_i = 2'($urandom_range(0, 3));
            voltage_sel_i    = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 199) == 0) auto_en_i = ~auto_en_i;
            activity_i       = ($urandom_range(0, 39) == 0);
            wake_i           = ($urandom_range(0, 15) == 0);
            if ($urandom_range(0, 5) == 0) power_good_i = ~power_good_i;
            power_fault_i    = ($urandom_range(0, 79) == 0);
            fault_clear_i    = ($urandom_range(0, 7) == 0);
            step();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
